dual_port_mem: RTL
==================

DUAL_PORT_MEM -- requirements
Module: dual_port_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning address width; DEPTH = 2^ADDR_W words.
REQ-003 The block SHALL have parameter RDW_MODE, default 0, meaning same-port read-during-write behaviour: 0 = write-first, 1 = read-first.
REQ-004 The block SHALL have parameter OUT_REG, default 0, meaning output pipeline: 0 = 1-cycle read latency, 1 = 2-cycle read latency.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 0, meaning 1 = zero-fill the whole array after reset.
REQ-006 The block SHALL have parameter INIT_FILE, default "" (no preload), meaning binary memory image loaded at elaboration.
REQ-007 The port list SHALL be as follows; one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- en_A  in  1  port A write enable
- addr_A  in  ADDR_W  port A address
- data_A  in  DATA_W  port A write data
- out_A  out  DATA_W  port A read data
- en_B, addr_B, data_B, out_B  same as port A, for port B
- busy  out  1  clear sequence in progress
- collision  out  1  one-cycle pulse: both ports wrote the same address

Function
REQ-008 Each port SHALL, every non-busy cycle, read ram[addr] and write data to ram[addr] when en is 1.
REQ-009 Read latency SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), from address sample to out valid; writes complete in 1 cycle.
REQ-010 On a same-port write with RDW_MODE=0, out SHALL present the newly written data; with RDW_MODE=1, out SHALL present the prior contents.
REQ-011 When one port writes and the other port reads the same address in the same cycle, the reading port SHALL return the prior contents, regardless of RDW_MODE.
REQ-012 When both ports write the same address in the same cycle, port A data SHALL be stored, and collision SHALL pulse high for exactly one cycle, aligned with the OUT_REG=0 read data.
REQ-013 Port reads of the same address by both ports SHALL both return identical data, with no collision.
REQ-014 The clear FSM SHALL have 2 states:
- IDLE: busy=0.
- CLEAR: busy=1; writes 0 to ram[clr_addr] each cycle and increments clr_addr.
REQ-015 The clear FSM SHALL transition CLEAR -> IDLE in the cycle it writes clr_addr = DEPTH-1; a full clear SHALL take exactly DEPTH cycles.
REQ-016 While busy=1, en_A/en_B SHALL be ignored (no user writes), out_A/out_B SHALL be 0, and collision SHALL be 0.
REQ-017 The clr_addr counter SHALL be ADDR_W bits and SHALL NOT wrap to re-clear.
REQ-018 User address arithmetic SHALL NOT exist; any addr value 0..DEPTH-1 SHALL be legal.

Reset
REQ-019 On reset, out_A, out_B and the OUT_REG pipeline stages SHALL be 0, and collision SHALL be 0.
REQ-020 On reset with CLEAR_ON_RESET=1, the FSM SHALL enter CLEAR with clr_addr=0 and busy=1 from the cycle after reset is sampled; with CLEAR_ON_RESET=0, the FSM SHALL enter IDLE with busy=0 and array contents retained.
REQ-021 Reset asserted mid-clear SHALL restart the clear from clr_addr=0.
REQ-022 Writes presented in a cycle where reset=1 SHALL be ignored.

Verification (bench at DATA_W=16, ADDR_W=4 unless noted)
REQ-023 The bench SHALL cover basic write then read: A writes 16'h1234 @3, next cycle B reads @3 -> out_B=16'h1234 one cycle later (two with OUT_REG=1).
REQ-024 The bench SHALL cover RDW modes: ram[5]=16'h0001; A writes 16'hBEEF @5 while reading @5 -> out_A=16'hBEEF (RDW_MODE=0) or 16'h0001 (RDW_MODE=1); B reading @5 same cycle -> 16'h0001 both modes.
REQ-025 The bench SHALL cover write collision: A writes 16'hAAAA and B writes 16'h5555 both @7 -> collision=1 for one cycle; later read @7 -> 16'hAAAA.
REQ-026 The bench SHALL cover clear: CLEAR_ON_RESET=1, preload all 16'hFFFF, 1-cycle reset -> busy=1 for exactly 16 cycles; write attempts ignored; afterwards every address reads 0.
REQ-027 The bench SHALL cover reset mid-clear: reset at clear cycle 9 -> busy stays 1 for a further full 16 cycles; all addresses read 0 afterwards.
REQ-028 The bench SHALL cover retain: CLEAR_ON_RESET=0, ram[2]=16'h00C3, reset pulse -> busy=0, outs=0 during reset, read @2 -> 16'h00C3.

Source files
------------

// File: rtl/dual_port_mem.sv
// Two-port synchronous RAM with per-port read-during-write policy, optional
// output register stage, write-collision flag and an optional post-reset zero-fill.
module dual_port_mem #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 0,
    parameter string       INIT_FILE      = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_A,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [DATA_W-1:0] data_A,
    output logic [DATA_W-1:0] out_A,
    input  logic              en_B,
    input  logic [ADDR_W-1:0] addr_B,
    input  logic [DATA_W-1:0] data_B,
    output logic [DATA_W-1:0] out_B,
    output logic              busy,
    output logic              collision
);

    localparam int unsigned DEPTH       = 1 << ADDR_W;
    localparam bit          WRITE_FIRST = (RDW_MODE == 0);
    localparam bit          AUTO_CLEAR  = (CLEAR_ON_RESET != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              user_cycle;

    // User traffic is accepted only outside reset and outside the clear sweep.
    assign user_cycle = !reset && (state == IDLE);

    // Clear sequencer: one word per cycle, stops after the last address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= AUTO_CLEAR ? CLEAR : IDLE;
            busy     <= AUTO_CLEAR;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            if (clr_addr == '1) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end
        end
    end

    // Array write; port A is applied last so it owns a same-address double write.
    always_ff @(posedge clk) begin
        if (!reset && (state == CLEAR)) begin
            ram[clr_addr] <= '0;
        end else if (user_cycle) begin
            if (en_B) begin
                ram[addr_B] <= data_B;
            end
            if (en_A) begin
                ram[addr_A] <= data_A;
            end
        end
    end

    // First read stage; the cross port always sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (!user_cycle) begin
            rd_a      <= '0;
            rd_b      <= '0;
            collision <= 1'b0;
        end else begin
            rd_a      <= (WRITE_FIRST && en_A) ? data_A : ram[addr_A];
            rd_b      <= (WRITE_FIRST && en_B) ? data_B : ram[addr_B];
            collision <= en_A && en_B && (addr_A == addr_B);
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] pipe_a;
        logic [DATA_W-1:0] pipe_b;

        always_ff @(posedge clk) begin
            if (reset) begin
                pipe_a <= '0;
                pipe_b <= '0;
            end else begin
                pipe_a <= rd_a;
                pipe_b <= rd_b;
            end
        end

        assign out_A = pipe_a;
        assign out_B = pipe_b;
    end else begin : g_no_out_reg
        assign out_A = rd_a;
        assign out_B = rd_b;
    end

endmodule
